widrow_hoff: RTL and testbench



---
 rtl/widrow_hoff.sv | 87 ++++++++
 tb/tb_widrow_hoff.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/widrow_hoff.sv
// Single-weight LMS (Widrow-Hoff) synapse: loads a 4-bit target serially, then
// applies a saturated weight correction in one CALC cycle.
//   IDLE | wait for start, capture first target bit and pixel
//   LOAD | shift remaining target bits, abort if start drops
//   CALC | form error, register dw and update weight
module widrow_hoff (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel,
  input  logic       sel,
  input  logic       y,
  input  logic       start,
  output logic [3:0] dw
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC} state_t;

  state_t      state, state_n;
  logic [3:0]  w;
  logic [3:0]  d;
  logic        xs;
  logic [1:0]  cnt;

  logic [4:0]  o5, e5, es5, sum5;
  logic [3:0]  dw_n, w_n;

  // Clamp a 5-bit two's-complement value into the 4-bit range -8..+7.
  function automatic logic [3:0] sat4(input logic [4:0] v);
    if (v[4] != v[3]) return v[4] ? 4'b1000 : 4'b0111;
    else              return v[3:0];
  endfunction

  always_comb begin
    o5   = xs ? {w[3], w} : 5'd0;
    e5   = {d[3], d} - o5;
    es5  = sel ? {e5[4], e5[4:1]} : e5;
    dw_n = xs ? sat4(es5) : 4'd0;
    sum5 = {w[3], w} + {dw_n[3], dw_n};
    w_n  = sat4(sum5);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = LOAD;
      LOAD: begin
        if (!start)          state_n = IDLE;
        else if (cnt == 2'd3) state_n = CALC;
      end
      CALC:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w   <= 4'd0;
      d   <= 4'd0;
      xs  <= 1'b0;
      cnt <= 2'd0;
      dw  <= 4'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          d   <= {d[2:0], y};
          xs  <= pixel;
          cnt <= 2'd1;
        end
        LOAD: if (start) begin
          d   <= {d[2:0], y};
          cnt <= cnt + 2'd1;
        end
        CALC: begin
          dw <= dw_n;
          w  <= w_n;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_widrow_hoff.sv
// Bench for widrow_hoff: directed learning/saturation/abort cases with literal
// expectations, then randomized frames checked every cycle against a frame-level model.
module tb_widrow_hoff;

  logic       clk, rst, pixel, sel, y, start;
  logic [3:0] dw;

  int total = 0;
  int bad   = 0;
  int exp_w  = 0;
  int exp_dw = 0;

  widrow_hoff dut (
    .clk(clk), .rst(rst), .pixel(pixel), .sel(sel),
    .y(y), .start(start), .dw(dw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 7)  return 7;
    if (v < -8) return -8;
    return v;
  endfunction

  // One completed frame, in plain integer arithmetic.
  task automatic model_frame(input logic [3:0] dbits, input logic px, input logic s);
    int dv, o, e, ep, corr;
    dv = (dbits >= 8) ? int'(dbits) - 16 : int'(dbits);
    o  = px ? exp_w : 0;
    e  = dv - o;
    if (s) ep = (e < 0 && (e % 2) != 0) ? (e - 1) / 2 : e / 2;
    else   ep = e;
    corr   = px ? clamp(ep) : 0;
    exp_dw = corr;
    exp_w  = clamp(exp_w + corr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      y = 1'($urandom); pixel = 1'($urandom); sel = 1'($urandom);
      tick();
    end
  endtask

  // nbits < 4 drops start after that many bits (abort).
  task automatic run_frame(input logic [3:0] dbits, input logic px, input logic s,
                           input int nbits, input logic calc_start);
    pixel = px;
    for (int i = 0; i < nbits; i++) begin
      start = 1'b1;
      y     = dbits[3-i];
      sel   = 1'($urandom);
      tick();
      pixel = 1'($urandom);
    end
    sel = s;
    y   = 1'($urandom);
    if (nbits == 4) begin
      start = calc_start;
      tick();
      model_frame(dbits, px, s);
    end else begin
      start = 1'b0;
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_dw", int'($signed(dw)), exp_dw);
      chk("cyc_w", int'($signed(dut.w)), exp_w);
    end
  end

  initial begin
    rst = 1'b0; start = 1'b0; y = 1'b0; pixel = 1'b0; sel = 1'b0;
    repeat (5) begin
      start = 1'($urandom); y = 1'($urandom); pixel = 1'($urandom); sel = 1'($urandom);
      tick();
    end
    chk("rst_dw", int'($signed(dw)), 0);
    chk("rst_w", int'($signed(dut.w)), 0);
    start = 1'b0;
    tick();
    rst = 1'b1;
    idle(4);

    run_frame(4'b0001, 1'b1, 1'b0, 4, 1'b0);
    chk("learn1_dw", int'($signed(dw)), 1); chk("learn1_w", int'($signed(dut.w)), 1);
    idle(2);
    run_frame(4'b0010, 1'b1, 1'b0, 4, 1'b0);
    chk("learn2_dw", int'($signed(dw)), 1); chk("learn2_w", int'($signed(dut.w)), 2);
    idle(2);
    run_frame(4'b0011, 1'b1, 1'b0, 4, 1'b0);
    chk("learn3_dw", int'($signed(dw)), 1); chk("learn3_w", int'($signed(dut.w)), 3);

    run_frame(4'b1010, 1'b0, 1'b0, 4, 1'b0);
    chk("zero_dw", int'($signed(dw)), 0); chk("zero_w", int'($signed(dut.w)), 3);

    run_frame(4'b0110, 1'b1, 1'b0, 2, 1'b0);
    chk("abort_dw", int'($signed(dw)), 0); chk("abort_w", int'($signed(dut.w)), 3);
    run_frame(4'b0101, 1'b1, 1'b0, 4, 1'b0);
    chk("post_abort_dw", int'($signed(dw)), 2); chk("post_abort_w", int'($signed(dut.w)), 5);

    // Asynchronous reset in the middle of a frame's load phase.
    start = 1'b1; y = 1'b1; pixel = 1'b1;
    tick(); tick();
    #2;
    rst = 1'b0;
    exp_w = 0; exp_dw = 0;
    #1;
    chk("rst_load_dw", int'($signed(dw)), 0);
    chk("rst_load_w", int'($signed(dut.w)), 0);
    chk("rst_load_cnt", int'(dut.cnt), 0);
    chk("rst_load_xs", int'(dut.xs), 0);
    start = 1'b0;
    tick();
    rst = 1'b1;
    idle(1);

    run_frame(4'b0111, 1'b1, 1'b1, 4, 1'b0);
    chk("half1_dw", int'($signed(dw)), 3); chk("half1_w", int'($signed(dut.w)), 3);
    run_frame(4'b1000, 1'b1, 1'b1, 4, 1'b0);
    chk("half2_dw", int'($signed(dw)), -6); chk("half2_w", int'($signed(dut.w)), -3);

    run_frame(4'b0111, 1'b1, 1'b0, 4, 1'b1);
    chk("sat_up_dw", int'($signed(dw)), 7); chk("sat_up_w", int'($signed(dut.w)), 4);
    run_frame(4'b0111, 1'b1, 1'b0, 4, 1'b0);
    chk("to7_w", int'($signed(dut.w)), 7);
    run_frame(4'b1000, 1'b1, 1'b0, 4, 1'b0);
    chk("satn_dw", int'($signed(dw)), -8); chk("satn_w", int'($signed(dut.w)), -1);
    run_frame(4'b1000, 1'b1, 1'b0, 4, 1'b0);
    chk("to_m8_w", int'($signed(dut.w)), -8);
    run_frame(4'b0111, 1'b1, 1'b0, 4, 1'b0);
    chk("satp_dw", int'($signed(dw)), 7); chk("satp_w", int'($signed(dut.w)), -1);

    for (int k = 0; k < 300; k++) begin
      logic [3:0] db;
      int nb;
      db = 4'($urandom);
      nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 4;
      run_frame(db, 1'($urandom), 1'($urandom), nb, 1'($urandom));
      idle(int'($urandom_range(0, 3)));
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
